rtc_init_sequencer: RTL and testbench

- Parametrised successor to the RTC power-up initialisation block.
- Walks a table of address/data write entries and presents each entry to the RTC bus write controller using a req/ack handshake.
- After each acknowledged write, enforces a programmable guard gap before the next entry.
- Supports two modes (full init, or clear chronometer/timer registers only), abort, ack timeout, and done/error reporting. Sits between the top-level control FSM and the RTC bus interface.

---
 rtl/rtc_init_pkg.sv | 41 ++++
 rtl/rtc_init_rom.sv | 25 ++
 rtl/rtc_init_sequencer.sv | 157 +++++++++++++++
 tb/tb_rtc_init_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_init_pkg.sv
// Shared definitions for the RTC init sequencer: state codes, index width and the
// default power-up write table.
package rtc_init_pkg;

  localparam int IDX_W         = 5;
  localparam int DEF_N_ENTRIES = 13;
  localparam int DEF_CLR_FIRST = 10;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_GAP    = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } rom_entry_t;

  // Entries 10..12 are the chronometer/timer clears used by the clear-only run.
  function automatic rom_entry_t def_entry(input logic [IDX_W-1:0] idx);
    rom_entry_t e;
    case (idx)
      5'd0:    e = '{addr: 8'h02, data: 8'h08};
      5'd1:    e = '{addr: 8'h02, data: 8'h00};
      5'd2:    e = '{addr: 8'h21, data: 8'h00};
      5'd3:    e = '{addr: 8'h22, data: 8'h00};
      5'd4:    e = '{addr: 8'h23, data: 8'h00};
      5'd5:    e = '{addr: 8'h24, data: 8'h00};
      5'd6:    e = '{addr: 8'h25, data: 8'h00};
      5'd7:    e = '{addr: 8'h26, data: 8'h00};
      5'd8:    e = '{addr: 8'h27, data: 8'h00};
      5'd9:    e = '{addr: 8'h28, data: 8'h00};
      5'd10:   e = '{addr: 8'h41, data: 8'h00};
      5'd11:   e = '{addr: 8'h42, data: 8'h00};
      5'd12:   e = '{addr: 8'h43, data: 8'h00};
      default: e = '{addr: 8'h00, data: 8'h00};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/rtc_init_rom.sv
// Combinational lookup from table index to {address, data}; indices at or beyond
// N_ENTRIES read as zero so the FSM never sees stale table contents.
module rtc_init_rom
  import rtc_init_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int N_ENTRIES = DEF_N_ENTRIES
) (
  input  logic [IDX_W-1:0]  i_idx,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data
);

  rom_entry_t w_entry;

  always_comb begin
    w_entry = def_entry(i_idx);
    if (int'(i_idx) >= N_ENTRIES) w_entry = '0;
  end

  assign o_addr = ADDR_W'(w_entry.addr);
  assign o_data = DATA_W'(w_entry.data);

endmodule

// File: rtl/rtc_init_sequencer.sv
// Walks the init table, one req/ack write per entry with a guard gap after each ack.
//   IDLE   | waiting for start, outputs parked at 0
//   ISSUE  | wr_req high on table[index], counting toward ack timeout
//   GAP    | guard gap after ack, address/data held
//   FINISH | one-cycle done pulse, then back to IDLE
module rtc_init_sequencer
  import rtc_init_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int N_ENTRIES   = DEF_N_ENTRIES,
  parameter int CLR_FIRST   = DEF_CLR_FIRST,
  parameter int HOLD_CYCLES = 74,
  parameter int TIMEOUT     = 1023,
  parameter int CNT_W       = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic              abort,
  input  logic              wr_ack,
  output logic              wr_req,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [IDX_W-1:0]  step
);

  localparam logic [CNT_W-1:0] HOLD_TC  = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] TMO_TC   = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ENTRIES - 1);
  localparam logic [IDX_W-1:0] CLR_IDX  = IDX_W'(CLR_FIRST);

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic              r_err;
  logic              r_wr_req;
  logic              r_busy;
  logic              r_done;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;

  logic [1:0]        w_state_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [IDX_W-1:0]  w_idx_nxt;
  logic              w_err_nxt;
  logic [ADDR_W-1:0] w_rom_addr;
  logic [DATA_W-1:0] w_rom_data;

  // Looked up with the next index so address/data register on the same edge as wr_req.
  rtc_init_rom #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .N_ENTRIES (N_ENTRIES)
  ) u_rom (
    .i_idx  (w_idx_nxt),
    .o_addr (w_rom_addr),
    .o_data (w_rom_data)
  );

  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_err_nxt   = r_err;
    case (r_state)
      ST_IDLE: begin
        if (start && !abort) begin
          w_state_nxt = ST_ISSUE;
          w_idx_nxt   = mode ? CLR_IDX : '0;
          w_cnt_nxt   = '0;
          w_err_nxt   = 1'b0;
        end
      end
      ST_ISSUE: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (wr_ack) begin
          w_state_nxt = ST_GAP;
          w_cnt_nxt   = CNT_W'(1);
        end else if (r_cnt >= TMO_TC) begin
          w_state_nxt = ST_FINISH;
          w_cnt_nxt   = '0;
          w_err_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      ST_GAP: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt >= HOLD_TC) begin
          w_cnt_nxt = '0;
          if (r_idx >= LAST_IDX) begin
            w_state_nxt = ST_FINISH;
          end else begin
            w_state_nxt = ST_ISSUE;
            w_idx_nxt   = r_idx + 1'b1;
          end
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_err    <= 1'b0;
      r_wr_req <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_idx    <= w_idx_nxt;
      r_err    <= w_err_nxt;
      r_wr_req <= (w_state_nxt == ST_ISSUE);
      r_busy   <= (w_state_nxt != ST_IDLE);
      r_done   <= (w_state_nxt == ST_FINISH);
      if (w_state_nxt == ST_ISSUE) begin
        r_addr <= w_rom_addr;
        r_data <= w_rom_data;
      end else if (w_state_nxt != ST_GAP) begin
        r_addr <= '0;
        r_data <= '0;
      end
    end
  end

  assign wr_req   = r_wr_req;
  assign address  = r_addr;
  assign data_out = r_data;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;
  assign step     = r_idx;

endmodule

// File: tb/tb_rtc_init_sequencer.sv
// Directed bench for rtc_init_sequencer: a transaction-level model predicts the
// outputs every cycle, plus literal checks on the write log and gap timing.
module tb_rtc_init_sequencer;

  localparam int HOLD = 74;
  localparam int TMO  = 1023;
  localparam int NENT = 13;
  localparam int CLRF = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic       abort = 1'b0;
  logic       wr_ack = 1'b0;
  logic       wr_req;
  logic [7:0] address;
  logic [7:0] data_out;
  logic       busy;
  logic       done;
  logic       err;
  logic [4:0] step;

  rtc_init_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .mode     (mode),
    .abort    (abort),
    .wr_ack   (wr_ack),
    .wr_req   (wr_req),
    .address  (address),
    .data_out (data_out),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .step     (step)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;
  int cyc = 0;

  logic [7:0] tbl_a [NENT] = '{8'h02, 8'h02, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25,
                               8'h26, 8'h27, 8'h28, 8'h41, 8'h42, 8'h43};
  logic [7:0] tbl_d [NENT] = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                               8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a run is a list of writes; each write holds wr_req until ack or
  // TMO cycles, then the bus stays quiet for HOLD+1 cycles counted from the ack.
  bit m_run = 0, m_req = 0, m_fin = 0, m_err = 0;
  int m_idx = 0, m_t = 0, m_g = 0;

  always @(posedge clk) cyc++;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_run = 0; m_req = 0; m_fin = 0; m_err = 0;
      m_idx = 0; m_t = 0; m_g = 0;
    end else if (!m_run) begin
      if (start && !abort) begin
        m_run = 1; m_req = 1; m_t = 1; m_err = 0;
        m_idx = mode ? CLRF : 0;
      end
    end else if (m_fin) begin
      m_fin = 0; m_run = 0;
    end else if (abort) begin
      m_run = 0; m_req = 0;
    end else if (m_req) begin
      if (wr_ack) begin
        m_req = 0; m_g = 1;
      end else if (m_t == TMO) begin
        m_req = 0; m_fin = 1; m_err = 1;
      end else begin
        m_t++;
      end
    end else begin
      m_g++;
      if (m_g == HOLD + 1) begin
        if (m_idx == NENT - 1) m_fin = 1;
        else begin
          m_idx++; m_req = 1; m_t = 1;
        end
      end
    end
  end

  function automatic logic [24:0] exp_bundle();
    logic [7:0] ea, ed;
    ea = 8'h00;
    ed = 8'h00;
    if (m_run && !m_fin) begin
      ea = tbl_a[m_idx];
      ed = tbl_d[m_idx];
    end
    return {m_run && m_req, m_run, m_fin, m_err, 5'(m_idx), ea, ed};
  endfunction

  always @(negedge clk) begin
    if (chk_on)
      chk($sformatf("outputs@%0d", cyc),
          {7'b0, wr_req, busy, done, err, step, address, data_out}, {7'b0, exp_bundle()});
  end

  // Bus responder and observation log.
  logic [7:0] log_a[$];
  logic [7:0] log_d[$];
  logic [4:0] log_s[$];
  int gaps[$];
  int req_len[$];
  int n_ack = 0, n_done = 0, last_ack_cyc = -1, age = 0;
  bit ack_en = 1'b1, no_ack_23 = 1'b0, prev_req = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (wr_req && !prev_req) begin
        log_a.push_back(address);
        log_d.push_back(data_out);
        log_s.push_back(step);
        if (last_ack_cyc >= 0) gaps.push_back(cyc - last_ack_cyc);
      end
      if (!wr_req && prev_req) req_len.push_back(age);
      age = wr_req ? age + 1 : 0;
      wr_ack = ack_en && wr_req && (age == 3) && !(no_ack_23 && address == 8'h23);
      if (wr_ack) begin
        n_ack++;
        last_ack_cyc = cyc;
      end
      if (done) n_done++;
      prev_req = wr_req;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_a.delete(); log_d.delete(); log_s.delete();
    gaps.delete(); req_len.delete();
    last_ack_cyc = -1;
  endtask

  task automatic pulse_start(input logic m);
    start = 1'b1; mode = m;
    tick();
    start = 1'b0; mode = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int k = 0;
    while (!done && k < budget) begin tick(); k++; end
    chk(tag, {31'b0, done}, 32'd1);
  endtask

  task automatic wait_writes(input int n, input int budget, input string tag);
    int k = 0;
    while (log_a.size() < n && k < budget) begin tick(); k++; end
    chk(tag, {31'b0, log_a.size() >= n}, 32'd1);
  endtask

  initial begin
    int nd0, k;
    #3 reset = 1'b0;
    chk_on = 1'b1;
    repeat (3) tick();
    chk("reset_outputs", {7'b0, wr_req, busy, done, err, step, address, data_out}, 32'd0);
    reset = 1'b1;
    repeat (2) tick();

    // Full init
    clear_log(); nd0 = n_done;
    pulse_start(1'b0);
    wait_done(2000, "full_done");
    chk("full_err", {31'b0, err}, 32'd0);
    repeat (2) tick();
    chk("full_ndone", n_done - nd0, 32'd1);
    chk("full_nwrites", log_a.size(), 32'd13);
    for (int i = 0; i < log_a.size() && i < NENT; i++) begin
      chk($sformatf("full_addr[%0d]", i), log_a[i], tbl_a[i]);
      chk($sformatf("full_data[%0d]", i), log_d[i], tbl_d[i]);
      chk($sformatf("full_step[%0d]", i), log_s[i], i);
    end
    chk("full_ngaps", gaps.size(), 32'd12);
    foreach (gaps[i]) chk($sformatf("full_gap[%0d]", i), gaps[i], 32'd75);

    // Clear only
    clear_log();
    pulse_start(1'b1);
    wait_done(500, "clr_done");
    tick();
    chk("clr_nwrites", log_a.size(), 32'd3);
    if (log_a.size() == 3) begin
      chk("clr_addr0", log_a[0], 32'h41);
      chk("clr_addr1", log_a[1], 32'h42);
      chk("clr_addr2", log_a[2], 32'h43);
      chk("clr_data", {log_d[0], log_d[1], log_d[2]}, 32'h0);
      chk("clr_step0", log_s[0], 32'd10);
      chk("clr_step2", log_s[2], 32'd12);
    end

    // Timeout on entry 4 (address 0x23)
    clear_log(); no_ack_23 = 1'b1;
    pulse_start(1'b0);
    wait_done(3000, "tmo_done");
    chk("tmo_err", {31'b0, err}, 32'd1);
    chk("tmo_len", (req_len.size() > 0) ? req_len[req_len.size()-1] : 0, 32'd1023);
    repeat (100) tick();
    chk("tmo_busy", {31'b0, busy}, 32'd0);
    chk("tmo_err_sticky", {31'b0, err}, 32'd1);
    chk("tmo_nwrites", log_a.size(), 32'd5);
    no_ack_23 = 1'b0;
    clear_log();
    pulse_start(1'b1);
    tick();
    chk("tmo_err_cleared", {31'b0, err}, 32'd0);
    wait_done(500, "tmo_rerun_done");
    tick();

    // Abort mid-GAP after the 5th write
    clear_log(); nd0 = n_done; k = n_ack;
    pulse_start(1'b0);
    begin
      int j = 0;
      while (n_ack - k < 5 && j < 1000) begin tick(); j++; end
      chk("abort_5acks", n_ack - k, 32'd5);
    end
    repeat (20) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_outputs", {7'b0, wr_req, busy, done, address, data_out}, 32'd0);
    chk("abort_step", step, 32'd4);
    repeat (10) tick();
    chk("abort_nodone", n_done - nd0, 32'd0);
    chk("abort_err", {31'b0, err}, 32'd0);

    // Restart from entry 0; then busy start and abort coincident with ack
    clear_log(); nd0 = n_done;
    pulse_start(1'b0);
    wait_writes(1, 20, "restart_write");
    if (log_a.size() > 0) begin
      chk("restart_addr", log_a[0], 32'h02);
      chk("restart_data", log_d[0], 32'h08);
      chk("restart_step", log_s[0], 32'd0);
    end
    start = 1'b1; mode = 1'b1;
    tick();
    start = 1'b0; mode = 1'b0;
    k = 0;
    while (!wr_ack && k < 20) begin tick(); k++; end
    chk("coinc_ack_seen", {31'b0, wr_ack}, 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("coinc_busy", {30'b0, busy, wr_req}, 32'd0);
    repeat (80) tick();
    chk("coinc_nwrites", log_a.size(), 32'd1);
    chk("coinc_nodone", n_done - nd0, 32'd0);
    chk("coinc_step", step, 32'd0);

    // Asynchronous reset mid-ISSUE
    clear_log();
    pulse_start(1'b0);
    wait_writes(1, 20, "areset_write");
    #2 reset = 1'b0;
    #1 chk("areset_outputs", {7'b0, wr_req, busy, done, err, step, address, data_out}, 32'd0);
    tick();
    reset = 1'b1;
    repeat (5) tick();
    chk("areset_idle", {31'b0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

endmodule
